// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss sequencer.
package dcache_pkg;

  localparam int unsigned LINE_LENGTH = 4;
  localparam int unsigned PA          = 22;
  localparam int unsigned NBEATS      = 2 * LINE_LENGTH;
  localparam int unsigned BEAT_W      = $clog2(NBEATS);
  localparam int unsigned OFF_W       = $clog2(LINE_LENGTH);
  localparam int unsigned LINE_AW     = PA - OFF_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_DATA   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_DATA = 3'd4
  } state_t;

  // Line address of a byte address (drops the in-line byte offset).
  function automatic logic [LINE_AW-1:0] line_of(input logic [PA-1:0] addr);
    return addr[PA-1:OFF_W];
  endfunction

endpackage

// File: rtl/dcache_beat_ctr.sv
// Nibble beat counter for one line burst; wraps to 0 after the last beat.
module dcache_beat_ctr
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last_c
);

  logic [BEAT_W-1:0] count;

  // Count beats while a data phase is active; clear on the burst grant.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + BEAT_W'(1);
    end
  end

  assign last_c = (count == BEAT_W'(NBEATS - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Miss sequencer: optional dirty write-back, line refill, then retry of the held access.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_flush,
  input  logic [PA-1:0]      paddr,
  input  logic               fault,
  input  logic [LINE_AW-1:0] victim_addr,
  input  logic               hit,
  input  logic               push,
  input  logic               pull,
  output logic               cpu_done,
  output logic               busy,
  output logic               flush_all,
  output logic               rstrobe_d,
  output logic               wstrobe_d,
  output logic               mem_req,
  output logic               mem_write,
  output logic [LINE_AW-1:0] mem_addr,
  input  logic               mem_ack
);

  state_t             state;
  logic [LINE_AW-1:0] fill_line;
  logic               beat_clear;
  logic               beat_en;
  logic               beat_last;

  // Byte offset inside the line plays no part in line sequencing.
  logic unused_offset;
  assign unused_offset = ^paddr[OFF_W-1:0];

  assign beat_clear = ((state == WB_REQ) || (state == FILL_REQ)) && mem_ack;
  assign beat_en    = (state == WB_DATA) || (state == FILL_DATA);

  dcache_beat_ctr u_beat_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (beat_clear),
    .enable (beat_en),
    .last_c (beat_last)
  );

  // Completion is only signalled from IDLE, in the same cycle as the request.
  assign cpu_done = (state == IDLE) && cpu_req && (fault || hit);

  // State sequencing with outputs registered against the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill_line <= '0;
      busy      <= 1'b0;
      flush_all <= 1'b0;
      rstrobe_d <= 1'b0;
      wstrobe_d <= 1'b0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
    end else begin
      flush_all <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && !fault && !hit) begin
            if (push) begin
              fill_line <= line_of(paddr);
              mem_addr  <= victim_addr;
              mem_write <= 1'b1;
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= WB_REQ;
            end else if (pull) begin
              fill_line <= line_of(paddr);
              mem_addr  <= line_of(paddr);
              mem_write <= 1'b0;
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= FILL_REQ;
            end
          end else if (!cpu_req && cpu_flush) begin
            flush_all <= 1'b1;
          end
        end
        WB_REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rstrobe_d <= 1'b1;
            state     <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (beat_last) begin
            rstrobe_d <= 1'b0;
            mem_addr  <= fill_line;
            mem_write <= 1'b0;
            mem_req   <= 1'b1;
            state     <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            wstrobe_d <= 1'b1;
            state     <= FILL_DATA;
          end
        end
        FILL_DATA: begin
          if (beat_last) begin
            wstrobe_d <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rstrobe_d <= 1'b0;
          wstrobe_d <= 1'b0;
          mem_req   <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: single-cycle vector table, directed misses, random traffic.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cpu_req, cpu_flush, fault, hit, push, pull, mem_ack;
  logic [PA-1:0]      paddr;
  logic [LINE_AW-1:0] victim_addr;
  logic               cpu_done, busy, flush_all, rstrobe_d, wstrobe_d, mem_req, mem_write;
  logic [LINE_AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_flush   (cpu_flush),
    .paddr       (paddr),
    .fault       (fault),
    .victim_addr (victim_addr),
    .hit         (hit),
    .push        (push),
    .pull        (pull),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .flush_all   (flush_all),
    .rstrobe_d   (rstrobe_d),
    .wstrobe_d   (wstrobe_d),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack)
  );

  typedef struct packed {
    logic               mem_req;
    logic               mem_write;
    logic [LINE_AW-1:0] mem_addr;
    logic               rstrobe_d;
    logic               wstrobe_d;
    logic               busy;
    logic               cpu_done;
    logic               flush_all;
  } obs_t;

  typedef struct {
    logic req, flush, flt, ht, psh, pll;
    logic exp_done, exp_flush;
  } vec_t;

  localparam int KIND_HIT = 0, KIND_FAULT = 1, KIND_CLEAN = 2, KIND_DIRTY = 3;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic fl, input logic flt, input logic ht,
                       input logic psh, input logic pll, input logic ack, input logic rst);
    cpu_req = req; cpu_flush = fl; fault = flt; hit = ht;
    push = psh; pull = pll; mem_ack = ack; reset = rst;
  endtask

  // Compare all outputs; address and direction only matter while a request is expected.
  task automatic check_obs(input string name, input int k, input obs_t exp);
    obs_t act;
    act.mem_req   = mem_req;
    act.mem_write = mem_write;
    act.mem_addr  = mem_addr;
    act.rstrobe_d = rstrobe_d;
    act.wstrobe_d = wstrobe_d;
    act.busy      = busy;
    act.cpu_done  = cpu_done;
    act.flush_all = flush_all;
    if (!exp.mem_req) begin
      act.mem_write = 1'b0; act.mem_addr = '0;
      exp.mem_write = 1'b0; exp.mem_addr = '0;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got req=%b wr=%b addr=%h rs=%b ws=%b busy=%b done=%b flush=%b, expected req=%b wr=%b addr=%h rs=%b ws=%b busy=%b done=%b flush=%b",
               name, k, act.mem_req, act.mem_write, act.mem_addr, act.rstrobe_d, act.wstrobe_d,
               act.busy, act.cpu_done, act.flush_all, exp.mem_req, exp.mem_write, exp.mem_addr,
               exp.rstrobe_d, exp.wstrobe_d, exp.busy, exp.cpu_done, exp.flush_all);
    end
  endtask

  // One access from the first request cycle through completion. Expected outputs come from
  // phase arithmetic: [optional WB req + 8 beats] -> fill req -> 8 beats -> retry hits.
  // d1/d2 are the extra request cycles before mem_ack; rst_k aborts with reset at that cycle.
  task automatic run_access(input string name, input int kind, input logic [PA-1:0] pa,
                            input logic [LINE_AW-1:0] vic, input int d1, input int d2,
                            input bit rnd, input int rst_k);
    int f0, done_k;
    logic [LINE_AW-1:0] line;
    obs_t e;
    logic ack;
    line   = pa[PA-1:OFF_W];
    f0     = (kind == KIND_DIRTY) ? 10 + d1 : 1;
    done_k = (kind < KIND_CLEAN) ? 0 : f0 + d2 + 9;
    paddr = pa;
    victim_addr = vic;
    for (int k = 0; k <= done_k; k++) begin
      ack = ((kind == KIND_DIRTY) && (k == 1 + d1)) || ((kind >= KIND_CLEAN) && (k == f0 + d2));
      if (k == 0) begin
        drive(1'b1, 1'b0, kind == KIND_FAULT, kind == KIND_HIT, kind == KIND_DIRTY,
              kind != KIND_HIT, ack, k == rst_k);
      end else if (k == done_k) begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ack, k == rst_k);
      end else if (rnd) begin
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), ack, k == rst_k);
      end else begin
        drive(1'b1, k == done_k - 1, 1'b0, 1'b0, kind == KIND_DIRTY, 1'b1, ack, k == rst_k);
      end
      e = '0;
      if (kind >= KIND_CLEAN && k > 0 && k < done_k) e.busy = 1'b1;
      if (kind == KIND_DIRTY && k >= 1 && k <= 1 + d1) begin
        e.mem_req = 1'b1; e.mem_write = 1'b1; e.mem_addr = vic;
      end
      if (kind == KIND_DIRTY && k >= 2 + d1 && k <= 9 + d1) e.rstrobe_d = 1'b1;
      if (kind >= KIND_CLEAN && k >= f0 && k <= f0 + d2) begin
        e.mem_req = 1'b1; e.mem_write = 1'b0; e.mem_addr = line;
      end
      if (kind >= KIND_CLEAN && k >= f0 + d2 + 1 && k <= f0 + d2 + 8) e.wstrobe_d = 1'b1;
      if (k == done_k) e.cpu_done = 1'b1;
      @(negedge clk);
      check_obs(name, k, e);
      next_cycle();
      if (k == rst_k) break;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_obs({name, " idle"}, done_k + 1, '0);
    next_cycle();
  endtask

  initial begin
    vec_t vecs[7];
    obs_t e;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // read hit
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // fault over pull
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // fault over push
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // hit over push
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // flush alone
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // flush ignored with req
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // quiet

    paddr = '0;
    victim_addr = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_obs("reset state", 0, '0);
    next_cycle();
    reset = 1'b0;

    paddr = PA'(22'h00102);
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].req, vecs[i].flush, vecs[i].flt, vecs[i].ht, vecs[i].psh, vecs[i].pll,
            1'b0, 1'b0);
      e = '0;
      e.cpu_done = vecs[i].exp_done;
      @(negedge clk);
      check_obs($sformatf("vec%0d", i), 0, e);
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e = '0;
      e.flush_all = vecs[i].exp_flush;
      @(negedge clk);
      check_obs($sformatf("vec%0d next", i), 1, e);
      next_cycle();
    end

    run_access("read hit", KIND_HIT, PA'(22'h00102), '0, 0, 0, 1'b0, -1);
    run_access("clean miss", KIND_CLEAN, PA'(22'h3F004), '0, 0, 0, 1'b0, -1);
    run_access("dirty miss", KIND_DIRTY, PA'(22'h12348), LINE_AW'(20'h00401), 3, 3, 1'b0, -1);
    run_access("fault", KIND_FAULT, PA'(22'h2A5A4), '0, 0, 0, 1'b0, -1);
    run_access("reset beat4", KIND_CLEAN, PA'(22'h3F004), '0, 0, 0, 1'b0, 5);
    run_access("after reset", KIND_CLEAN, PA'(22'h01230), '0, 1, 0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      run_access($sformatf("rand%0d", i), int'($urandom_range(3, 0)), PA'($urandom),
                 LINE_AW'($urandom), int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss sequencer for the direct-mapped data cache. It sits between the CPU load/store port, the cache array and the nibble-wide external memory bus. On a miss it optionally writes back the dirty victim line, refills the line, and stalls the CPU until the retried access hits. The 4-bit data path runs directly between the cache and memory; this block only sequences addresses, requests and beat strobes.

## Interface
- LINE_LENGTH, 4, cache line length in bytes; one line is 2*LINE_LENGTH nibble beats
- PA, 22, physical address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  load/store request; held stable with paddr until cpu_done
- cpu_flush  in  1  request to invalidate the whole cache
- paddr  in  PA  access address, shared with the cache
- fault  in  1  MMU fault for the current access
- victim_addr  in  PA-log2(LINE_LENGTH)  line address of the resident line at paddr's index
- hit, push, pull  in  1 each  cache status for paddr
- cpu_done  out  1  access complete, combinational
- busy  out  1  state != IDLE
- flush_all  out  1  one-cycle cache invalidate
- rstrobe_d  out  1  write-back beat: the cache advances its nibble offset
- wstrobe_d  out  1  refill beat: the cache captures the memory nibble
- mem_req  out  1  memory burst request
- mem_write  out  1  1 = write-back burst, 0 = refill burst
- mem_addr  out  PA-log2(LINE_LENGTH)  burst line address
- mem_ack  in  1  one-cycle grant; 2*LINE_LENGTH beats follow on consecutive cycles, no gaps

## Operation
States: IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA.

- **IDLE**
  - cpu_req && fault: cpu_done=1, no transition, no cache or memory action.
  - cpu_req && hit: cpu_done=1.
  - cpu_req && push: latch victim_addr and the fill line address paddr[PA-1:log2 LL], then go to WB_REQ.
  - cpu_req && pull && !push: latch the fill line address, then go to FILL_REQ.
  - cpu_flush with no cpu_req: flush_all=1 for that cycle. cpu_flush is ignored outside IDLE and whenever cpu_req is high.
- **WB_REQ**
  - Outputs: mem_req=1, mem_write=1, mem_addr = latched victim address.
  - mem_ack: clear the beat counter and go to WB_DATA.
- **WB_DATA**
  - rstrobe_d=1 every cycle; the counter increments.
  - When the counter reaches 2*LINE_LENGTH-1: go to FILL_REQ.
- **FILL_REQ**
  - Outputs: mem_req=1, mem_write=0, mem_addr = latched fill address.
  - mem_ack: clear the counter and go to FILL_DATA.
- **FILL_DATA**
  - wstrobe_d=1 every cycle.
  - Last beat: go to IDLE. The held request is re-evaluated there, now hits, and completes.
- Beat counter is log2(2*LINE_LENGTH) bits and wraps to 0 after the last beat. The strobes are never gapped, because the cache resets its nibble offset on any strobe-free cycle.
- cpu_req deasserting mid-miss does not abort the burst; the line completes.
- fault, hit, push and pull are ignored outside IDLE.

## Timing
- Reset values: state IDLE, counter 0, latched addresses 0, every output 0.
- Outputs are Moore-decoded from the state, except cpu_done (combinational in IDLE).
- Hit: cpu_done in the same cycle as cpu_req, zero stall.
- Clean miss (LINE_LENGTH=4, mem_ack on the first request cycle):
  - cycle 0 IDLE miss; cycle 1 FILL_REQ; cycles 2-9 wstrobe_d; cycle 10 cpu_done.
- Dirty miss: 9 extra cycles (1 WB_REQ + 8 rstrobe_d beats), so cpu_done in cycle 19.
- mem_req stays high in a REQ state until mem_ack; ack latency is unbounded.
- mem_req drops in the first beat cycle.
- Reset mid-burst: IDLE next cycle, strobes and mem_req deassert immediately. The memory side shares the same reset.

## Structure
- dcache_pkg holds:
  - the state enum;
  - NBEATS = 2*LINE_LENGTH;
  - BEAT_W = $clog2(NBEATS);
  - LINE_AW = PA-$clog2(LINE_LENGTH).
- One sub-module, dcache_beat_ctr: clear, enable, and a last flag at NBEATS-1.
- The FSM and the address latches stay in dcache_ctrl.

## Test plan
- Read hit (hit=1, cpu_req=1, paddr=0x00102) -> cpu_done in the same cycle; mem_req, rstrobe_d and wstrobe_d stay 0.
- Clean read miss at paddr=0x3F004, mem_ack in the first request cycle:
  - mem_addr=0x0FC01, mem_write=0;
  - exactly 8 consecutive wstrobe_d cycles;
  - cpu_done at cycle 10.
- Dirty write miss with victim_addr=0x00401 and mem_ack delayed 3 cycles:
  - write-back burst to 0x00401 with 8 rstrobe_d, then a refill burst to the paddr line;
  - the request states hold mem_req through the delay.
- Faulting access (fault=1, hit=0, pull=1) -> cpu_done immediately; busy never rises.
- reset asserted on refill beat 4 -> next cycle state IDLE, all outputs 0; a new miss then runs a full 8-beat burst.
- cpu_flush in IDLE -> single-cycle flush_all; cpu_flush during FILL_DATA -> no flush_all.
